data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised successor to the processor's 128x8 data memory: configurable width and depth, registered read with a valid strobe, and a hardware clear sequence after reset.
- Sits between the datapath load/store unit and the storage array.
- Rejects accesses while the clear sequence is running and flags them.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W words.
- CLEAR_VAL, 0, value written to every word during the clear sequence (DATA_W bits).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr  in  ADDR_W  word address for read or write.
- rd  in  1  read request, sampled on rising edge.
- wr  in  1  write request, sampled on rising edge.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  registered read data; holds last value until the next accepted read.
- rvalid  out  1  one-cycle pulse; rdata is valid.
- busy  out  1  high while the clear sequence runs.
- err  out  1  one-cycle pulse; a request arrived while busy and was dropped.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: rdata=0, rvalid=0, err=0, busy=1. Clear pointer=0. FSM goes to CLEAR.
- Array contents are not reset directly; they are written by the CLEAR sequence.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes CLEAR_VAL to mem[ptr], then ptr increments.
  - When ptr==DEPTH-1 is written, the next state is READY and busy drops that same edge.
  - The sequence takes exactly DEPTH cycles after rst deasserts.
- READY: busy=0. Stays in READY until rst.
- Reset mid-operation: rst in any state (including mid-CLEAR) restarts CLEAR from ptr=0. Any pending rvalid or err is cancelled.
- Write (READY, wr=1): mem[addr] <= wdata on the edge.
- Read (READY, rd=1):
  - rdata <= mem[addr] on the edge; rvalid=1 in the following cycle.
  - Latency is 1 cycle.
  - Back-to-back reads are allowed every cycle; rvalid stays high across consecutive accepted reads.
- rd=0: rvalid=0 and rdata holds.
- Simultaneous rd and wr:
  - Different addresses: both are performed.
  - Same address: governed by the Optional Feature.
- Requests while busy (rd or wr in CLEAR): dropped, with no array or rdata change and no rvalid. err pulses for 1 cycle on the following cycle.
- Address width: addr is exactly ADDR_W bits, so there is no out-of-range case. Clear pointer is ADDR_W+1 bits so the terminal count is unambiguous.

Optional Feature:
- Macro: DATA_MEM_BYPASS_EN.
- Defined: same-address rd+wr in READY returns the new data (rdata <= wdata, write-first).
- Undefined: same-address rd+wr returns the old contents (read-first). The array write still happens.
- err and rvalid behaviour is identical in both builds.

Decomposition:
- Package data_mem_pkg holds:
  - the FSM state enum (ST_CLEAR, ST_READY);
  - default constants DMEM_DATA_W=8 and DMEM_ADDR_W=7.
- Sub-module data_mem_array: a plain synchronous-write, synchronous-read storage array parametrised on DATA_W/ADDR_W, with one write port and one read port. It keeps storage inference clean.
- data_mem_ctrl owns the FSM, clear pointer, bypass mux, and rvalid/err generation.

Test Plan:
- Clear sequence (defaults):
  - rst for 2 cycles, then release → busy=1 for exactly 128 cycles, then 0.
  - Reading addr 0, 64 and 127 afterwards → rdata=0x00 with rvalid one cycle after each rd.
- Write/read:
  - wr addr=0x05 wdata=0xA5, next cycle rd addr=0x05 → one cycle later rdata=0xA5, rvalid=1 for one cycle.
  - Reads of 0x04/0x06 → 0x00.
- Back-to-back reads:
  - Fill addr 0..3 with 0x10..0x13, then rd on four consecutive cycles → rvalid high for 4 cycles, rdata=0x10,0x11,0x12,0x13 in order.
- Same-address rd+wr:
  - mem[0x20]=0x11, then rd=wr=1 addr=0x20 wdata=0x22 → rdata=0x22 with DATA_MEM_BYPASS_EN, 0x11 without.
  - A follow-up read → 0x22 in both builds.
- Busy rejection and mid-clear reset:
  - wr at cycle 10 of CLEAR → err pulses once, no rvalid.
  - After READY, that address reads 0x00.
  - Assert rst at cycle 50 of CLEAR → busy stays high, READY is reached exactly 128 cycles after the new release.
- Parameter sweep: DATA_W=16, ADDR_W=4, CLEAR_VAL=0xFFFF → busy for 16 cycles; all 16 words read 0xFFFF; write/read 0xBEEF round-trips.

Source files
------------

// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared types and default constants for the data memory
//            controller (FSM state encoding, default geometry).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

   // Default geometry matches the original 128x8 data memory
   localparam int DMEM_DATA_W = 8;
   localparam int DMEM_ADDR_W = 7;

   // Controller states: hardware clear in progress, or serving requests
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } dmem_state_e;

endpackage : data_mem_pkg

`default_nettype wire

// File: rtl/data_mem_array.sv
// ============================================================================
// Module   : data_mem_array
// Brief    : Plain storage array, one synchronous write port and one
//            synchronous read port. No reset on the contents or the read
//            register so that block RAM inference stays clean. A read and
//            write to the same address on one edge returns the old contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: output register only updates on an enabled read, so it holds
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : data_mem_array

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Parametrised data memory controller. After reset it walks the
//            whole array writing CLEAR_VAL (busy high), then serves reads and
//            writes. Reads have one cycle latency with an rvalid strobe;
//            requests arriving during the clear are dropped and flagged on err.
// Config   : DATA_MEM_BYPASS_EN - when defined, a simultaneous read and write
//            (always the same address, addr is shared) returns the new data
//            (write-first). When undefined the old contents are returned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int                DATA_W    = DMEM_DATA_W,
   parameter int                ADDR_W    = DMEM_ADDR_W,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              err
);

   localparam int DEPTH = 1 << ADDR_W;
   // One extra bit so the terminal count can never alias address zero
   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   dmem_state_e       state;
   logic [PTR_W-1:0]  ptr;

   logic              ready;
   logic              rd_ok;
   logic              wr_ok;
   logic              byp_hit;

   logic              arr_we;
   logic [ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   // Read-result tracking: have_data masks the unreset array register until
   // the first accepted read; use_byp/byp_data carry the write-first value.
   logic              have_data;
   logic              use_byp;
   logic [DATA_W-1:0] byp_data;

   assign ready = (state == ST_READY);
   assign rd_ok = ready & rd & ~rst;
   assign wr_ok = ready & wr & ~rst;

`ifdef DATA_MEM_BYPASS_EN
   // rd and wr share addr, so a simultaneous pair is always same-address
   assign byp_hit = rd_ok & wr_ok;
`else
   assign byp_hit = 1'b0;
`endif

   // Array write port source: clear walker while clearing, datapath otherwise
   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = addr;
      arr_wdata = wdata;
      if (state == ST_CLEAR) begin
         arr_we    = ~rst;
         arr_waddr = ptr[ADDR_W-1:0];
         arr_wdata = CLEAR_VAL;
      end else begin
         arr_we    = wr_ok;
      end
   end

   data_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (rd_ok),
      .raddr (addr),
      .rdata (arr_rdata)
   );

   // FSM and clear pointer; busy drops on the edge that writes the last word
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else if (state == ST_CLEAR) begin
         ptr <= ptr + 1'b1;
         if (ptr == PTR_LAST) begin
            state <= ST_READY;
         end
      end
   end

   // Response strobes and read-result selection state
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid    <= 1'b0;
         err       <= 1'b0;
         have_data <= 1'b0;
         use_byp   <= 1'b0;
         byp_data  <= '0;
      end else begin
         rvalid <= rd_ok;
         err    <= ~ready & (rd | wr);
         if (rd_ok) begin
            have_data <= 1'b1;
            use_byp   <= byp_hit;
            byp_data  <= wdata;
         end
      end
   end

   assign busy  = (state == ST_CLEAR);
   assign rdata = !have_data ? '0 : (use_byp ? byp_data : arr_rdata);

endmodule : data_mem_ctrl

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed self-checking bench for data_mem_ctrl: default 128x8
//            instance plus a 16x16 instance with an all-ones clear value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance
   logic        rst = 1'b1;
   logic [6:0]  addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        busy;
   logic        err;

   // 16x16 instance
   logic        rst_b = 1'b1;
   logic [3:0]  addr_b = '0;
   logic        rd_b = 1'b0;
   logic        wr_b = 1'b0;
   logic [15:0] wdata_b = '0;
   logic [15:0] rdata_b;
   logic        rvalid_b;
   logic        busy_b;
   logic        err_b;

   int n_checks = 0;
   int n_err    = 0;

`ifdef DATA_MEM_BYPASS_EN
   localparam logic [7:0] EXP_SAME = 8'h22;
`else
   localparam logic [7:0] EXP_SAME = 8'h11;
`endif

   data_mem_ctrl u_dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .rd     (rd),
      .wr     (wr),
      .wdata  (wdata),
      .rdata  (rdata),
      .rvalid (rvalid),
      .busy   (busy),
      .err    (err)
   );

   data_mem_ctrl #(
      .DATA_W    (16),
      .ADDR_W    (4),
      .CLEAR_VAL (16'hFFFF)
   ) u_dut_b (
      .clk    (clk),
      .rst    (rst_b),
      .addr   (addr_b),
      .rd     (rd_b),
      .wr     (wr_b),
      .wdata  (wdata_b),
      .rdata  (rdata_b),
      .rvalid (rvalid_b),
      .busy   (busy_b),
      .err    (err_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_a(input logic [6:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   task automatic read_a(input string tag, input logic [6:0] a, input logic [7:0] exp);
      addr = a; rd = 1'b1;
      tick();
      rd = 1'b0;
      check({tag, " rvalid"}, 32'(rvalid), 32'd1);
      check({tag, " rdata"}, 32'(rdata), 32'(exp));
      tick();
      check({tag, " rvalid drop"}, 32'(rvalid), 32'd0);
      check({tag, " rdata hold"}, 32'(rdata), 32'(exp));
   endtask

   // Counts edges after release until busy drops (bounded)
   task automatic count_busy_a(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < 400);
   endtask

   initial begin
      int n;

      // ---- Reset and clear sequence ----
      rst = 1'b1;
      tick(); tick();
      check("reset busy", 32'(busy), 32'd1);
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rdata", 32'(rdata), 32'd0);
      rst = 1'b0;
      count_busy_a(n);
      check("clear length", 32'(n), 32'd128);
      check("ready busy", 32'(busy), 32'd0);

      read_a("clr a0", 7'd0, 8'h00);
      read_a("clr a64", 7'd64, 8'h00);
      read_a("clr a127", 7'd127, 8'h00);

      // ---- Write / read ----
      write_a(7'h05, 8'hA5);
      read_a("wr a5", 7'h05, 8'hA5);
      read_a("rd a4", 7'h04, 8'h00);
      read_a("rd a6", 7'h06, 8'h00);

      // ---- Back-to-back reads ----
      for (int i = 0; i < 4; i++) write_a(7'(i), 8'(8'h10 + i));
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr = 7'(i);
         tick();
         if (i == 3) rd = 1'b0;
         check($sformatf("b2b rvalid %0d", i), 32'(rvalid), 32'd1);
         check($sformatf("b2b rdata %0d", i), 32'(rdata), 32'(8'h10 + i));
      end
      tick();
      check("b2b rvalid end", 32'(rvalid), 32'd0);

      // ---- Same-address read + write ----
      write_a(7'h20, 8'h11);
      addr = 7'h20; wdata = 8'h22; rd = 1'b1; wr = 1'b1;
      tick();
      rd = 1'b0; wr = 1'b0;
      check("same rvalid", 32'(rvalid), 32'd1);
      check("same rdata", 32'(rdata), 32'(EXP_SAME));
      tick();
      read_a("same follow", 7'h20, 8'h22);

      // ---- Busy rejection ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (9) tick();
      addr = 7'h03; wdata = 8'h77; wr = 1'b1;
      tick();                               // clear edge 10
      wr = 1'b0;
      check("busy wr err", 32'(err), 32'd1);
      check("busy wr rvalid", 32'(rvalid), 32'd0);
      tick();
      check("busy err pulse", 32'(err), 32'd0);

      // ---- Mid-clear reset cancels pending err ----
      repeat (37) tick();                   // edges 12..48
      addr = 7'h10; rd = 1'b1;
      tick();                               // edge 49
      rd = 1'b0;
      check("busy rd err", 32'(err), 32'd1);
      check("busy rd rvalid", 32'(rvalid), 32'd0);
      rst = 1'b1;
      tick();                               // edge 50
      rst = 1'b0;
      check("midrst err", 32'(err), 32'd0);
      check("midrst busy", 32'(busy), 32'd1);
      count_busy_a(n);
      check("midrst clear length", 32'(n), 32'd128);
      read_a("dropped wr a3", 7'h03, 8'h00);
      read_a("recleared a5", 7'h05, 8'h00);

      // ---- 16x16 instance, CLEAR_VAL all ones ----
      tick();
      check("b reset busy", 32'(busy_b), 32'd1);
      rst_b = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy_b && n < 100);
      check("b clear length", 32'(n), 32'd16);
      rd_b = 1'b1;
      for (int i = 0; i < 16; i++) begin
         addr_b = 4'(i);
         tick();
         if (i == 15) rd_b = 1'b0;
         check($sformatf("b clr rvalid %0d", i), 32'(rvalid_b), 32'd1);
         check($sformatf("b clr rdata %0d", i), 32'(rdata_b), 32'h0000FFFF);
      end
      addr_b = 4'd9; wdata_b = 16'hBEEF; wr_b = 1'b1;
      tick();
      wr_b = 1'b0;
      check("b wr no rvalid", 32'(rvalid_b), 32'd0);
      rd_b = 1'b1;
      tick();
      rd_b = 1'b0;
      check("b rt rvalid", 32'(rvalid_b), 32'd1);
      check("b rt rdata", 32'(rdata_b), 32'h0000BEEF);
      check("b err", 32'(err_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_data_mem_ctrl

`default_nettype wire
